// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, sequencer states and datapath width shared by the multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } st_e;

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one iteration of shift-add multiply or restoring divide on a {hi,lo} accumulator.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           ge;

    // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
    // and the top bit of the difference is a clean borrow flag.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, b};
        ge       = ~diff[WIDTH];
        acc_next = is_div ? {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                          : {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/DIV sequencer owning HI/LO, with PC stall and MT/MF access.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    st_e                state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_rs, abs_rt;
    logic               neg_q_q, neg_q_d, neg_r_q, neg_r_d, div_q, div_d;
    logic               done_q, done_d, dz_q, dz_d;
    logic               is_md, signed_op;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (state_q == ST_DIV),
        .acc      (acc_q),
        .b        (b_q),
        .acc_next (acc_step)
    );

    assign is_md     = op_valid && !op[2];
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign abs_rs    = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign abs_rt    = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign prod      = neg_q_q ? -acc_q : acc_q;

    assign stall    = (state_q == ST_IDLE && is_md) || state_q inside {ST_MUL, ST_DIV, ST_FIX};
    assign mf_data  = !op_valid ? '0 : op == MD_MFHI ? hi_q : op == MD_MFLO ? lo_q : '0;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = dz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        div_d   = div_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_md) begin
                    neg_q_d = signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    neg_r_d = signed_op && rs_data[WIDTH-1];
                    div_d   = op[1];
                    cnt_d   = CW'(WIDTH - 1);
                    if (op[1] && rt_data == '0) begin
                        // Divide by zero short-circuits: raw results, no sign fixup.
                        lo_d    = '1;
                        hi_d    = rs_data;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, op[1] ? abs_rs : abs_rt};
                        b_d     = op[1] ? abs_rt : abs_rs;
                        state_d = op[1] ? ST_DIV : ST_MUL;
                    end
                end else if (op_valid && op == MD_MTHI) begin
                    hi_d = rs_data;
                end else if (op_valid && op == MD_MTLO) begin
                    lo_d = rs_data;
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d   = acc_step;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? ST_FIX : state_q;
            end
            ST_FIX: begin
                hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH]
                                 : neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            div_q   <= div_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed checks of multiply, divide, divide-by-zero, reset abort and MT/MF paths.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    md_op_e      op = MD_MFHI;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall, done, div_zero;
    logic [31:0] mf_data, hi, lo;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo),
        .done     (done),
        .div_zero (div_zero)
    );

    // Issues one op and follows it to its done pulse; lat=-1 if done never arrives.
    task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic dz, output logic st_done);
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        #1 stalls = int'(stall);
        lat = -1; dz = 1'b0; st_done = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1 op_valid = 1'b0;
            #1;
            if (done) begin
                lat = k; dz = div_zero; st_done = stall;
                break;
            end
            stalls += int'(stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", done, div_zero); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        int lat, stalls; logic dz, sd;
        run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, lat, stalls, dz, sd);
        checks++; if (lat !== 34) begin failures++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        checks++; if (stalls !== 34) begin failures++; $display("FAIL mult_stall_cycles got=%0d exp=34", stalls); end
        checks++; if (sd !== 1'b0) begin failures++; $display("FAIL mult_stall_at_done got=%b exp=0", sd); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL mult_div_zero got=%b exp=0", dz); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_result got=%h/%h exp=ffffffff/fffffff1", hi, lo); end
    endtask

    task automatic test_multu_mf();
        int lat, stalls; logic dz, sd;
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, stalls, dz, sd);
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin failures++; $display("FAIL multu_result got=%h/%h exp=fffffffe/00000001", hi, lo); end
        @(posedge clk); #1 op_valid = 1'b1; op = MD_MFHI;
        #1;
        checks++; if (mf_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL mfhi_data got=%h exp=fffffffe", mf_data); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mfhi_stall got=%b exp=0", stall); end
        op = MD_MFLO;
        #1;
        checks++; if (mf_data !== 32'h00000001) begin failures++; $display("FAIL mflo_data got=%h exp=00000001", mf_data); end
        op_valid = 1'b0;
        #1;
        checks++; if (mf_data !== 32'h0) begin failures++; $display("FAIL mf_idle got=%h exp=0", mf_data); end
    endtask

    task automatic test_div();
        int lat, stalls; logic dz, sd;
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, lat, stalls, dz, sd);
        checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", lat); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_result got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
        run_op(MD_DIVU, 32'd7, 32'd2, lat, stalls, dz, sd);
        checks++; if (hi !== 32'd1 || lo !== 32'd3) begin failures++; $display("FAIL divu_result got=%h/%h exp=1/3", hi, lo); end
        run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, lat, stalls, dz, sd);
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negdivisor got=%h/%h exp=1/fffffffd", hi, lo); end
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat, stalls, dz, sd);
        checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin failures++; $display("FAIL div_overflow got=%h/%h exp=0/80000000", hi, lo); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_overflow_flag got=%b exp=0", dz); end
    endtask

    task automatic test_div_zero();
        int lat, stalls; logic dz, sd;
        run_op(MD_DIVU, 32'd7, 32'd0, lat, stalls, dz, sd);
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        checks++; if (stalls !== 1) begin failures++; $display("FAIL dz_stall_cycles got=%0d exp=1", stalls); end
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", dz); end
        checks++; if (hi !== 32'd7 || lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_result got=%h/%h exp=7/ffffffff", hi, lo); end
        @(posedge clk); #2;
        checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin failures++; $display("FAIL dz_pulse_width got=%b%b exp=00", done, div_zero); end
    endtask

    task automatic test_reset_abort();
        int lat, stalls; logic dz, sd; logic seen = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b1; op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1 op_valid = 1'b0;
            if (k == 10) rst_n = 1'b0;
            #1 seen |= done;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b exp=0", stall); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if ((seen | done) !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", seen | done); end
        run_op(MD_MULT, 32'd6, 32'd7, lat, stalls, dz, sd);
        checks++; if (lat !== 34) begin failures++; $display("FAIL post_abort_latency got=%0d exp=34", lat); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin failures++; $display("FAIL post_abort_mult got=%h/%h exp=0/2a", hi, lo); end
    endtask

    task automatic test_mt_mf();
        logic st_seen = 1'b0;
        @(posedge clk); #1 op_valid = 1'b1; op = MD_MTHI; rs_data = 32'h12345678;
        #1 st_seen |= stall;
        @(posedge clk); #1 op = MD_MTLO; rs_data = 32'hCAFEBABE;
        #1 st_seen |= stall;
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_reg got=%h exp=12345678", hi); end
        @(posedge clk); #1 op = MD_MFHI; rs_data = 32'h0;
        #1 st_seen |= stall;
        checks++; if (mf_data !== 32'h12345678) begin failures++; $display("FAIL mt_mfhi got=%h exp=12345678", mf_data); end
        @(posedge clk); #1 op = MD_MFLO;
        #1 st_seen |= stall;
        checks++; if (mf_data !== 32'hCAFEBABE) begin failures++; $display("FAIL mt_mflo got=%h exp=cafebabe", mf_data); end
        checks++; if (st_seen !== 1'b0) begin failures++; $display("FAIL mt_mf_stall got=%b exp=0", st_seen); end
        @(posedge clk); #1 op_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_mf();
        test_div();
        test_div_zero();
        test_reset_abort();
        test_mt_mf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide unit with its sequencer, sitting beside the single-cycle ALU in the 31-instruction MIPS core. It receives the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO opcode from instruction decode and owns the HI/LO registers. It runs 32-step shift-add multiply or restoring divide, and holds the PC via stall until the result is committed.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
op_valid  input  1  decode presents a valid MDU op this cycle
op  input  3  MDU opcode (package enum)
rs_data  input  WIDTH  register-file rs read data (dividend/multiplicand/MT source)
rt_data  input  WIDTH  register-file rt read data (divisor/multiplier)
stall  output  1  hold PC and suppress RF write
mf_data  output  WIDTH  HI or LO for MFHI/MFLO, to RF write mux
hi  output  WIDTH  current HI register
lo  output  WIDTH  current LO register
done  output  1  one-cycle pulse when MULT/DIV result is committed
div_zero  output  1  one-cycle pulse, coincident with done, when divisor was 0

Behaviour:
- Reset (rst_n low at clock edge): state=IDLE, hi=lo=0, counter=0, done=div_zero=0, stall=0. Reset during MUL/DIV/FIX aborts the op; HI/LO end at 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, op_valid, op in {MULT,MULTU,DIV,DIVU} (issue cycle T):
  - Capture magnitudes of rs/rt (signed ops: two's-complement abs; unsigned: raw). Record result signs: product = rs^rt; quotient = rs^rt; remainder = sign of rs.
  - Counter loads WIDTH-1. Next state MUL or DIV.
- MUL/DIV: one iteration per cycle, T+1..T+32. Leave to FIX when counter==0 in the current cycle.
  - Multiply: 64-bit shift-add.
  - Divide: restoring; quotient bit = 1 when partial remainder >= divisor.
- FIX (T+33): negate results per recorded signs. Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient) at end of cycle.
- DONE (T+34): done=1, stall=0, op input ignored. Next state IDLE. Decode advances past the instruction on this edge.
- stall = (state==IDLE & op_valid & op is MULT/DIV kind) | state in {MUL,DIV,FIX}. Combinational. High T..T+33, low T+34. Total 35 cycles.
- Divide by zero, detected at issue:
  - Skip iteration; next state DONE at T+1.
  - LO=all-ones, HI=rs_data raw, written at end of T. Signs not applied.
  - div_zero=1 with done at T+1. stall high only in T.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This is the natural wrap; no flag.
- MTHI/MTLO in IDLE: write rs_data at end of cycle; stall=0.
- MFHI/MFLO: mf_data = hi/lo combinationally (registered value). stall=0. mf_data=0 for other ops.
- MT/MF need no stall against a running op: the core is single-issue and stall blocks further fetch.
- op_valid with an undefined op code: no effect.

Decomposition:
- Package mdu_pkg holds:
  - op enum: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MFHI=4, MD_MFLO=5, MD_MTHI=6, MD_MTLO=7.
  - State enum.
  - WIDTH constant.
- One sub-module, mdu_iter_step: combinational single-iteration datapath (shift-add step and restore-subtract step).
- The sequencer FSM, counter, sign fixup and HI/LO stay in the top.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> stall high 34 cycles; done at T+34; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MFHI next cycle gives mf_data=0xFFFFFFFE, stall=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with DIVU 7/2 -> LO=3, HI=1.
- DIVU rs=7, rt=0 -> stall only in T; done and div_zero pulse at T+1; LO=0xFFFFFFFF, HI=7.
- Issue DIV 100/7, assert rst_n=0 at T+10 -> next cycle state IDLE, stall=0, HI=LO=0; no done pulse. New MULT 6*7 then gives LO=42, HI=0.
- MTHI rs=0x12345678, then MTLO rs=0xCAFEBABE, then MFHI/MFLO -> mf_data 0x12345678 / 0xCAFEBABE; stall never asserted.
